mux_nto1_rr: RTL and testbench
==============================

MUX_NTO1_RR -- requirements
Module: mux_nto1_rr

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels (legal range 2..16).
REQ-002 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-003 SHALL derive local SELW = $clog2(N), width of channel-index signals.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-007 SHALL have port sel  input  SELW  channel index used when mode=0.
REQ-008 SHALL have port in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port in_valid  input  N  per-channel valid.
REQ-010 SHALL have port in_ready  output  N  per-channel ready, at most one bit high.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_chan  output  SELW  index of channel that supplied out_data.
REQ-013 SHALL have port out_valid  output  1  out_data/out_chan valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts when high with out_valid.

Function
REQ-015 SHALL define load = ~out_valid | out_ready (output register free or draining this cycle).
REQ-016 SHALL, in mode=0, grant channel sel when in_valid[sel]=1; no grant otherwise; no grant if sel >= N.
REQ-017 SHALL, in mode=1, grant the first channel with in_valid=1 searching ptr, ptr+1, ..., wrapping N-1 -> 0; no grant if in_valid is all 0.
REQ-018 SHALL drive in_ready[g]=1 only for granted channel g, and only when load=1; all other bits 0 (combinational from in_valid, mode, sel, ptr, out_valid, out_ready).
REQ-019 SHALL, on a rising edge with in_valid[g] & in_ready[g], capture in_data[g] into out_data, g into out_chan, and set out_valid=1 (latency 1 cycle).
REQ-020 SHALL, on a rising edge with out_valid & out_ready and no input transfer, clear out_valid; out_data/out_chan hold last value.
REQ-021 SHALL, with out_valid=1 and out_ready=0, hold out_data, out_chan, out_valid stable and drive in_ready all 0.
REQ-022 SHALL support simultaneous output drain and input capture in one cycle, giving full throughput of one word per cycle.
REQ-023 SHALL keep round-robin pointer ptr (SELW bits); on each accepted input transfer from channel g update ptr to (g+1) mod N, in either mode.
REQ-024 SHALL wrap ptr from N-1 to 0; ptr never holds a value >= N.
REQ-025 SHALL apply mode/sel changes to the next grant decision only; a word already in the output register is unaffected; ptr is retained across mode changes.
REQ-026 SHALL never drop or duplicate a word: each input handshake yields exactly one output handshake, in acceptance order.

Reset
REQ-027 SHALL, while rst=1 (asynchronously, independent of clk), force out_valid=0, out_data=0, out_chan=0, ptr=0, and in_ready all 0.
REQ-028 SHALL, on rst asserted mid-transfer, discard any held output word; first grant after release starts search at channel 0.
REQ-029 SHALL begin accepting inputs on the first rising edge after rst deasserts.

Verification (N=4, WIDTH=8)
REQ-030 SHALL cover reset: rst=1 with in_valid=4'b1111 -> out_valid=0, out_data=8'h00, in_ready=4'b0000; after release first capture is channel 0.
REQ-031 SHALL cover fixed mode: mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> next cycle out_data=8'hA5, out_chan=2, out_valid=1; sel=3 with in_valid[3]=0 -> in_ready=4'b0000.
REQ-032 SHALL cover round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1, ch i data=8'h10+i -> out_chan sequence 0,1,2,3,0 with data 8'h10..8'h13,8'h10, one per cycle.
REQ-033 SHALL cover skip and wrap: mode=1, ptr=3, in_valid=4'b0010 -> grant ch1, ptr becomes 2; then in_valid=4'b0001 -> grant ch0 (wrap).
REQ-034 SHALL cover backpressure: out_valid=1, out_ready=0 for 5 cycles -> out_data/out_chan stable, in_ready=4'b0000; out_ready=1 -> held word drains and next word captured same edge.
REQ-035 SHALL cover reset mid-stream: mode=1, stream running, rst pulsed between edges -> out_valid falls immediately without clk edge; after release, grant order restarts at ch0.

Source files
------------

// File: rtl/mux_nto1_rr.sv
// ---------------------------------------------------------------------------
// mux_nto1_rr
//   N-to-1 valid/ready multiplexer with a single registered output stage.
//   mode=0 selects channel `sel` directly; mode=1 arbitrates round-robin,
//   starting the search at the channel after the last one accepted.
//   Full throughput: the output word may drain and a new word load on the
//   same edge.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed mode
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (one-hot or zero)
//   out_data   registered selected data
//   out_chan   index of the channel that supplied out_data
//   out_valid  out_data/out_chan valid
//   out_ready  downstream accept
// ---------------------------------------------------------------------------
module mux_nto1_rr #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [SELW-1:0] LAST_CHAN = SELW'(N - 1);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_chan_q,  out_chan_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic             load;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt_idx;
    logic             xfer;
    int               rr_c;

    // Output register is free, or is being emptied on this edge.
    assign load = ~out_valid_q | out_ready;

    // Grant decision. The round-robin search walks offsets from the far end
    // down to zero so the closest valid channel after ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_c    = 0;
        if (!mode) begin
            if (int'(sel) < N) begin
                if (in_valid[sel]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = sel;
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                rr_c = int'(ptr_q) + k;
                if (rr_c >= N) begin
                    rr_c = rr_c - N;
                end
                if (in_valid[rr_c]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(rr_c);
                end
            end
        end
    end

    // rst gates ready directly: while reset is held the flops read empty,
    // which would otherwise look like load=1.
    always_comb begin
        in_ready = '0;
        if (gnt_vld && load && !rst) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_comb begin
        out_valid_d = out_valid_q & ~out_ready;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
            out_chan_d  = gnt_idx;
            ptr_d       = (gnt_idx == LAST_CHAN) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Bench for mux_nto1_rr with N=4, WIDTH=8: directed scenarios against fixed
// expected values, then randomized traffic against a cycle reference model.
module tb_mux_nto1_rr;
    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int SELW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_nto1_rr #(.N(N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Reference model: output register contents and the next channel to
    // search from, kept as plain integers.
    bit         m_ov;
    logic [7:0] m_data;
    int         m_chan;
    int         m_ptr;

    function automatic int ref_grant(input bit md, input int s, input logic [3:0] v, input int p);
        int c;
        if (!md) return (s < N && v[s]) ? s : -1;
        for (int k = 0; k < N; k++) begin
            c = (p + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] ref_ready();
        int g;
        g = ref_grant(mode, int'(sel), in_valid, m_ptr);
        if (rst || g < 0 || !(!m_ov || out_ready)) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            m_ov   = 1'b0;
            m_data = 8'h00;
            m_chan = 0;
            m_ptr  = 0;
        end else begin
            g = ref_grant(mode, int'(sel), in_valid, m_ptr);
            if ((!m_ov || out_ready) && g >= 0) begin
                m_ov   = 1'b1;
                m_data = in_data[g*WIDTH +: WIDTH];
                m_chan = g;
                m_ptr  = (g + 1) % N;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
        @(negedge clk); rst = 1'b0; #1;
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_release_ready got %b want 0001", in_ready); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'h10)
            begin n_fail++; $display("FAIL reset_first_capture got v=%b ch=%0d d=%h want v=1 ch=0 d=10", out_valid, out_chan, out_data); end
    endtask

    task automatic test_fixed();
        @(negedge clk);
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        in_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        #1;
        n_checks++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL fixed_ready got %b want 0100", in_ready); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== 8'hA5)
            begin n_fail++; $display("FAIL fixed_capture got v=%b ch=%0d d=%h want v=1 ch=2 d=a5", out_valid, out_chan, out_data); end
        @(negedge clk); sel = 2'd3; #1;
        n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL fixed_no_grant got %b want 0000", in_ready); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_chan !== 2'd2)
            begin n_fail++; $display("FAIL fixed_drain_hold got v=%b ch=%0d d=%h want v=0 ch=2 d=a5", out_valid, out_chan, out_data); end
    endtask

    task automatic test_skip_wrap();
        // Park ptr at 3 by taking a word from channel 2.
        @(negedge clk); mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        in_data = {8'h33, 8'h22, 8'h11, 8'h00};
        @(negedge clk); mode = 1'b1; in_valid = 4'b0010; #1;
        n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL skip_ready got %b want 0010", in_ready); end
        @(posedge clk); #1;
        n_checks++; if (out_chan !== 2'd1 || out_data !== 8'h11) begin n_fail++; $display("FAIL skip_chan got ch=%0d d=%h want ch=1 d=11", out_chan, out_data); end
        @(negedge clk); in_valid = 4'b0001; #1;
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_ready got %b want 0001", in_ready); end
        @(posedge clk); #1;
        n_checks++; if (out_chan !== 2'd0 || out_data !== 8'h00) begin n_fail++; $display("FAIL wrap_chan got ch=%0d d=%h want ch=0 d=00", out_chan, out_data); end
        @(negedge clk); in_valid = 4'b1110; #1;
        n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_ptr_next got %b want 0010", in_ready); end
        @(posedge clk);
    endtask

    task automatic test_rr_fair();
        @(negedge clk); rst = 1'b1; #2; rst = 1'b0;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_checks++; if (in_ready !== (4'b0001 << (k % 4)))
                begin n_fail++; $display("FAIL rr_ready[%0d] got %b want %b", k, in_ready, 4'b0001 << (k % 4)); end
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1 || int'(out_chan) != k % 4 || out_data !== 8'h10 + 8'(k % 4))
                begin n_fail++; $display("FAIL rr_seq[%0d] got v=%b ch=%0d d=%h want ch=%0d", k, out_valid, out_chan, out_data, k % 4); end
        end
    endtask

    task automatic test_backpressure();
        // Held word is channel 0 / 8'h10; ptr is 1.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); out_ready = 1'b0; #1;
            n_checks++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0000", k, in_ready); end
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'h10)
                begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b ch=%0d d=%h want v=1 ch=0 d=10", k, out_valid, out_chan, out_data); end
        end
        @(negedge clk); out_ready = 1'b1; #1;
        n_checks++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready got %b want 0010", in_ready); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== 8'h11)
            begin n_fail++; $display("FAIL bp_drain_capture got v=%b ch=%0d d=%h want v=1 ch=1 d=11", out_valid, out_chan, out_data); end
        @(negedge clk); in_valid = 4'b0000;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0 || out_chan !== 2'd1 || out_data !== 8'h11)
            begin n_fail++; $display("FAIL bp_drain_only got v=%b ch=%0d d=%h want v=0 ch=1 d=11", out_valid, out_chan, out_data); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_stream_running got %b want 1", out_valid); end
        #2; rst = 1'b1; #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0 || in_ready !== 4'b0000)
            begin n_fail++; $display("FAIL mid_async_reset got v=%b d=%h ch=%0d rdy=%b want 0/00/0/0000", out_valid, out_data, out_chan, in_ready); end
        @(negedge clk); rst = 1'b0; #1;
        n_checks++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_restart_ready got %b want 0001", in_ready); end
        @(posedge clk); #1;
        n_checks++; if (out_chan !== 2'd0 || out_data !== 8'h10) begin n_fail++; $display("FAIL mid_restart_chan got ch=%0d d=%h want ch=0 d=10", out_chan, out_data); end
    endtask

    task automatic test_random();
        logic [3:0] exp_rdy;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = 32'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = ref_ready();
            n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready[%0d] got %b want %b", k, in_ready, exp_rdy); end
            @(posedge clk); #1;
            n_checks++; if (out_valid !== m_ov || out_data !== m_data || int'(out_chan) != m_chan)
                begin n_fail++; $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d", k, out_valid, out_data, out_chan, m_ov, m_data, m_chan); end
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_skip_wrap();
        test_rr_fair();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
